// File: rtl/traffic_phase_sched_if.sv
// rtl/traffic_phase_sched_if.sv - controller <-> datapath/junction signal bundle (emerg present with EMERG_PREEMPT_EN)
interface traffic_phase_sched_if #(
   parameter int W = 6
);
   logic         sens_cntry;
   logic         ped_btn;
   logic         cnt_zero;
`ifdef EMERG_PREEMPT_EN
   logic         emerg;
`endif
   logic         load;
   logic [W-1:0] load_val;
   logic [1:0]   hwy;
   logic [1:0]   cntry;
   logic         walk;
   logic [2:0]   state;

`ifdef EMERG_PREEMPT_EN
   modport master (
      input  sens_cntry, ped_btn, cnt_zero, emerg,
      output load, load_val, hwy, cntry, walk, state
   );
   modport slave (
      output sens_cntry, ped_btn, cnt_zero, emerg,
      input  load, load_val, hwy, cntry, walk, state
   );
`else
   modport master (
      input  sens_cntry, ped_btn, cnt_zero,
      output load, load_val, hwy, cntry, walk, state
   );
   modport slave (
      output sens_cntry, ped_btn, cnt_zero,
      input  load, load_val, hwy, cntry, walk, state
   );
`endif
endinterface

// File: rtl/traffic_phase_sched.sv
// rtl/traffic_phase_sched.sv - highway/country/pedestrian phase controller; EMERG_PREEMPT_EN adds emergency preemption
module traffic_phase_sched #(
   parameter int W         = 6,
   parameter int T_HWY_MIN = 20,
   parameter int T_YEL     = 5,
   parameter int T_RED     = 1,
   parameter int T_CNTRY   = 10,
   parameter int T_WALK    = 8
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   traffic_phase_sched_if.master bus
);

   typedef enum logic [2:0] {
      S_HG = 3'd0, S_HY = 3'd1, S_AR = 3'd2, S_CG = 3'd3,
      S_CY = 3'd4, S_PW = 3'd5, S_X6 = 3'd6, S_X7 = 3'd7
   } state_t;

   typedef enum logic [1:0] {N_HWY = 2'd0, N_CNTRY = 2'd1, N_PED = 2'd2} next_t;
   typedef enum logic {G_CNTRY = 1'b0, G_PED = 1'b1} grant_t;

   localparam logic [1:0] L_GRN = 2'b00;
   localparam logic [1:0] L_YEL = 2'b01;
   localparam logic [1:0] L_RED = 2'b10;

   state_t       state_q, state_d;
   next_t        nxt_q, nxt_d;
   grant_t       last_grant_q, last_grant_d;
   logic         pend_c_q, pend_c_d;
   logic         pend_p_q, pend_p_d;
   logic         armed_q, armed_d;
   logic         enter_q, enter_d;
   logic         load_q, load_d;
   logic [W-1:0] load_val_q, load_val_d;
   logic         ped_prev_q, ped_prev_d;

   logic         ped_rise;
   logic         set_c, set_p;
   logic         clr_c, clr_p;
   logic         expire;
   logic         emerg_act;

`ifdef EMERG_PREEMPT_EN
   assign emerg_act = bus.emerg;
`else
   assign emerg_act = 1'b0;
`endif

   // Duration loaded into the datapath when a phase is entered.
   function automatic logic [W-1:0] phase_dur(state_t s);
      case (s)
         S_HG:       phase_dur = W'(T_HWY_MIN);
         S_HY, S_CY: phase_dur = W'(T_YEL);
         S_AR:       phase_dur = W'(T_RED);
         S_CG:       phase_dur = W'(T_CNTRY);
         S_PW:       phase_dur = W'(T_WALK);
         default:    phase_dur = '0;
      endcase
   endfunction

   // Register all controller state; reset lands in a pre-entry HG that loads on release.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q      <= S_HG;
         nxt_q        <= N_HWY;
         last_grant_q <= G_PED;
         pend_c_q     <= 1'b0;
         pend_p_q     <= 1'b0;
         armed_q      <= 1'b0;
         enter_q      <= 1'b1;
         load_q       <= 1'b0;
         load_val_q   <= '0;
         ped_prev_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         nxt_q        <= nxt_d;
         last_grant_q <= last_grant_d;
         pend_c_q     <= pend_c_d;
         pend_p_q     <= pend_p_d;
         armed_q      <= armed_d;
         enter_q      <= enter_d;
         load_q       <= load_d;
         load_val_q   <= load_val_d;
         ped_prev_q   <= ped_prev_d;
      end
   end

   // Next-state, request latching, grant arbitration and load sequencing.
   always_comb begin
      state_d      = state_q;
      nxt_d        = nxt_q;
      last_grant_d = last_grant_q;
      clr_c        = 1'b0;
      clr_p        = 1'b0;

      ped_rise = bus.ped_btn && !ped_prev_q;
      set_c    = bus.sens_cntry && (state_q != S_CG) && (state_q != S_CY);
      set_p    = ped_rise && (state_q != S_PW);
      // Stale zero left over from the previous phase must never end the new one.
      expire   = bus.cnt_zero && armed_q && !load_q;

      case (state_q)
         S_HG: begin
            // Counter sits at zero after the minimum, so expire stays true until a request shows up.
            if (expire && (pend_c_q || pend_p_q) && !emerg_act) state_d = S_HY;
         end
         S_HY: begin
            if (expire) begin
               state_d = S_AR;
               if (pend_c_q && pend_p_q)
                  nxt_d = (last_grant_q == G_PED) ? N_CNTRY : N_PED;
               else if (pend_c_q)
                  nxt_d = N_CNTRY;
               else if (pend_p_q)
                  nxt_d = N_PED;
               else
                  nxt_d = N_HWY;
            end
         end
         S_AR: begin
            if (expire) begin
               case (nxt_q)
                  N_CNTRY: begin
                     state_d      = S_CG;
                     clr_c        = 1'b1;
                     last_grant_d = G_CNTRY;
                  end
                  N_PED: begin
                     state_d      = S_PW;
                     clr_p        = 1'b1;
                     last_grant_d = G_PED;
                  end
                  default: state_d = S_HG;
               endcase
            end
         end
         S_CG: begin
            if (expire || emerg_act) state_d = S_CY;
         end
         S_CY: begin
            if (expire) begin
               state_d = S_AR;
               nxt_d   = N_HWY;
            end
         end
         S_PW: begin
            if (expire || emerg_act) begin
               state_d = S_AR;
               nxt_d   = N_HWY;
            end
         end
         default: state_d = S_HG;
      endcase

      // Grant clear beats a same-cycle set; otherwise set wins.
      pend_c_d = clr_c ? 1'b0 : (pend_c_q || set_c);
      pend_p_d = clr_p ? 1'b0 : (pend_p_q || set_p);

      load_d     = enter_q || (state_d != state_q);
      load_val_d = load_d ? phase_dur(state_d) : load_val_q;
      armed_d    = load_d ? 1'b0 : (load_q ? 1'b1 : armed_q);
      enter_d    = 1'b0;
      ped_prev_d = bus.ped_btn;
   end

   // Lamp decode of the current state; unused codes show all red.
   always_comb begin
      bus.hwy   = L_RED;
      bus.cntry = L_RED;
      bus.walk  = 1'b0;
      case (state_q)
         S_HG: bus.hwy   = L_GRN;
         S_HY: bus.hwy   = L_YEL;
         S_CG: bus.cntry = L_GRN;
         S_CY: bus.cntry = L_YEL;
         S_PW: bus.walk  = 1'b1;
         default: ;
      endcase
   end

   assign bus.load     = load_q;
   assign bus.load_val = load_val_q;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// tb/tb_traffic_phase_sched.sv - self-checking bench for traffic_phase_sched
module tb_traffic_phase_sched;
   localparam int W = 6;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   traffic_phase_sched_if #(.W(W)) bus ();

   traffic_phase_sched #(
      .W(W), .T_HWY_MIN(20), .T_YEL(5), .T_RED(1), .T_CNTRY(10), .T_WALK(8)
   ) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .bus      (bus)
   );

   // Datapath stand-in: loadable down-counter that rests at zero.
   logic [W-1:0] cnt;
   logic         force_zero = 1'b0;
   always_ff @(posedge clk) begin
      if (reset)          cnt <= '0;
      else if (bus.load)  cnt <= bus.load_val;
      else if (cnt != '0) cnt <= cnt - 1'b1;
   end
   assign bus.cnt_zero = (cnt == '0) || force_zero;

   int n_checks = 0;
   int n_pass   = 0;
   int n_loads  = 0;
   int cyc      = 0;
   int last_load_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0] st;
      int         gap;
   } exp_t;
   exp_t sb_q[$];
   exp_t e;

   typedef struct {
      bit         rst;
      bit         c;
      bit         p;
      bit         c_again;
      logic [2:0] svc1;
      logic [2:0] svc2;
   } scen_t;
   scen_t scen [5];

   function automatic int ref_dur(logic [2:0] s);
      case (s)
         3'd0:       return 20;
         3'd1, 3'd4: return 5;
         3'd2:       return 1;
         3'd3:       return 10;
         3'd5:       return 8;
         default:    return 0;
      endcase
   endfunction

   // {hwy, cntry, walk}
   function automatic int ref_lamps(logic [2:0] s);
      case (s)
         3'd0:    return 5'b00_10_0;
         3'd1:    return 5'b01_10_0;
         3'd3:    return 5'b10_00_0;
         3'd4:    return 5'b10_01_0;
         3'd5:    return 5'b10_10_1;
         default: return 5'b10_10_0;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Scoreboard side: every load strobe must match the next expected phase entry.
   always @(negedge clk) begin
      if (!reset && bus.load) begin
         n_loads++;
         if (sb_q.size() == 0) begin
            check("spurious_load_state", int'(bus.state), -1);
         end else begin
            e = sb_q.pop_front();
            check("load_state", int'(bus.state), int'(e.st));
            check("load_val", int'(bus.load_val), ref_dur(e.st));
            check("lamps", int'({bus.hwy, bus.cntry, bus.walk}), ref_lamps(e.st));
            if (e.gap >= 0) check("phase_gap", cyc - last_load_cyc, e.gap);
         end
         last_load_cyc = cyc;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_state", int'(bus.state), 0);
      check("rst_hwy", int'(bus.hwy), 0);
      check("rst_cntry", int'(bus.cntry), 2);
      check("rst_walk", int'(bus.walk), 0);
      check("rst_load", int'(bus.load), 0);
      check("rst_load_val", int'(bus.load_val), 0);
      sb_q.delete();
      sb_q.push_back('{3'd0, -1});
      reset = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("drain_remaining", sb_q.size(), 0);
      sb_q.delete();
   endtask

   task automatic wait_load_of(input logic [2:0] s, input string name);
      int  n = 0;
      bit  found = 1'b0;
      while (!found && n < 300) begin
         @(negedge clk);
         n++;
         found = bus.load && (bus.state == s);
      end
      check(name, int'(found), 1);
   endtask

   task automatic push_service(input logic [2:0] svc, input int hy_gap);
      sb_q.push_back('{3'd1, hy_gap});
      sb_q.push_back('{3'd2, 7});
      sb_q.push_back('{svc, 3});
      if (svc == 3'd3) begin
         sb_q.push_back('{3'd4, 12});
         sb_q.push_back('{3'd2, 7});
      end else begin
         sb_q.push_back('{3'd2, 10});
      end
      sb_q.push_back('{3'd0, 3});
   endtask

   task automatic pulse_sens();
      bus.sens_cntry = 1'b1;
      @(negedge clk);
      bus.sens_cntry = 1'b0;
   endtask

   initial begin
      bus.sens_cntry = 1'b0;
      bus.ped_btn    = 1'b0;
`ifdef EMERG_PREEMPT_EN
      bus.emerg      = 1'b0;
`endif
      //           rst c  p  again svc1  svc2
      scen[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 3'd0};
      scen[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd0};
      scen[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 3'd5};
      scen[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 3'd0};
      scen[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 3'd3};

      // No requests: one HG load, then HG holds with no reload.
      do_reset();
      wait_drain();
      repeat (60) @(negedge clk);
      check("idle_hg_state", int'(bus.state), 0);
      check("idle_hg_loads", n_loads, 1);

      for (int i = 0; i < 5; i++) begin
         if (scen[i].rst) begin
            do_reset();
            wait_drain();
         end
         repeat (3) @(negedge clk);
         push_service(scen[i].svc1, scen[i].rst ? 22 : -1);
         if (scen[i].svc2 != 3'd0) push_service(scen[i].svc2, 22);
         bus.sens_cntry = scen[i].c;
         bus.ped_btn    = scen[i].p;
         @(negedge clk);
         bus.sens_cntry = 1'b0;
         if (scen[i].c_again) begin
            wait_load_of(scen[i].svc1, "reach_service");
            repeat (3) @(negedge clk);
            pulse_sens();
         end
         wait_drain();
         bus.ped_btn = 1'b0;
         repeat (40) @(negedge clk);
         check("scen_end_state", int'(bus.state), 0);
      end

      // Zero held across the HY load edge must not end HY early.
      push_service(3'd3, -1);
      pulse_sens();
      wait_load_of(3'd1, "reach_hy_zero");
      force_zero = 1'b1;
      @(negedge clk);
      check("zero_hold_state", int'(bus.state), 1);
      force_zero = 1'b0;
      wait_drain();
      repeat (40) @(negedge clk);

      // Reset in the middle of CG returns to a fresh HG.
      push_service(3'd3, -1);
      pulse_sens();
      wait_load_of(3'd3, "reach_cg_mid");
      repeat (2) @(negedge clk);
      do_reset();
      wait_drain();
      repeat (40) @(negedge clk);
      check("post_rst_state", int'(bus.state), 0);

`ifdef EMERG_PREEMPT_EN
      // Emergency in CG cuts straight to CY.
      sb_q.push_back('{3'd1, -1});
      sb_q.push_back('{3'd2, 7});
      sb_q.push_back('{3'd3, 3});
      sb_q.push_back('{3'd4, 3});
      sb_q.push_back('{3'd2, 7});
      sb_q.push_back('{3'd0, 3});
      pulse_sens();
      wait_load_of(3'd3, "reach_cg_emerg");
      repeat (2) @(negedge clk);
      bus.emerg = 1'b1;
      @(negedge clk);
      bus.emerg = 1'b0;
      wait_drain();
      repeat (40) @(negedge clk);

      // Emergency in HG holds HG while a country request waits.
      bus.emerg = 1'b1;
      pulse_sens();
      repeat (40) @(negedge clk);
      check("emerg_hg_hold", int'(bus.state), 0);
      push_service(3'd3, -1);
      bus.emerg = 1'b0;
      wait_drain();
      repeat (40) @(negedge clk);
      check("emerg_end_state", int'(bus.state), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
